// File: rtl/store_align_unit_if.sv
// Store path bus bundle: request side from EXE/MEM, beat side to the data-memory write port.
// master = the alignment unit, slave = the pipeline/memory environment around it.
interface store_align_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    localparam int NB = XLEN / 8;

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [NB-1:0]     mem_wmask;

    logic              store_err;
    logic              busy;

    modport master (
        input  req_valid, req_size, req_addr, req_wdata, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_wmask, store_err, busy
    );

    modport slave (
        output req_valid, req_size, req_addr, req_wdata, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wmask, store_err, busy
    );
endinterface

// File: rtl/store_align_unit.sv
// Store alignment unit: turns a right-aligned store request into a word-aligned
// bus beat (address, lane-shifted data, byte mask).
// Build option: STORE_ALIGN_SPLIT_EN -- when defined, word-crossing stores are
// issued as two beats; when undefined they are rejected with a store_err pulse.
module store_align_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input logic                 clk,
    input logic                 rst,
    store_align_unit_if.master  bus
);
    localparam int NB    = XLEN / 8;
    localparam int OFS_W = $clog2(NB);

`ifdef STORE_ALIGN_SPLIT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BEAT_LAST = 2'd1, BEAT_FIRST = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, BEAT_LAST = 2'd1} state_t;
`endif

    state_t            r_state;
    state_t            w_next;
    state_t            w_first_state;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [XLEN-1:0]   r_mem_wdata;
    logic [NB-1:0]     r_mem_wmask;
    logic              r_store_err;

    logic [OFS_W-1:0]  w_off;
    logic [OFS_W+2:0]  w_sh;
    logic [3:0]        w_bytes;
    logic [4:0]        w_end;
    logic              w_cross;
    logic              w_illegal;
    logic              w_reject;
    logic              w_accept;
    logic              w_req_ready;
    logic              w_load_lo;
    logic              w_load_hi;
    logic              w_err;
    logic [NB-1:0]     w_lane_mask;
    logic [XLEN-1:0]   w_lane_data;
    logic [ADDR_W-1:0] w_base;
    logic [NB-1:0]     w_lo_mask;
    logic [XLEN-1:0]   w_lo_data;

    assign w_off     = bus.req_addr[OFS_W-1:0];
    assign w_sh      = {w_off, 3'b000};
    assign w_bytes   = 4'd1 << bus.req_size;
    assign w_end     = 5'(w_off) + 5'(w_bytes);
    assign w_cross   = w_end > 5'(NB);
    assign w_illegal = (XLEN == 32) && (bus.req_size == 2'b11);
    assign w_base    = {bus.req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
    assign w_lo_mask = NB'({{NB{1'b0}}, w_lane_mask} << w_off);
    assign w_lo_data = XLEN'({{XLEN{1'b0}}, w_lane_data} << w_sh);

`ifdef STORE_ALIGN_SPLIT_EN
    logic [ADDR_W-1:0] r_hi_addr;
    logic [XLEN-1:0]   r_hi_wdata;
    logic [NB-1:0]     r_hi_wmask;
    logic [NB-1:0]     w_hi_mask;
    logic [XLEN-1:0]   w_hi_data;

    assign w_hi_mask     = NB'(({{NB{1'b0}}, w_lane_mask} << w_off) >> NB);
    assign w_hi_data     = XLEN'(({{XLEN{1'b0}}, w_lane_data} << w_sh) >> XLEN);
    assign w_reject      = w_illegal;
    assign w_first_state = w_cross ? BEAT_FIRST : BEAT_LAST;
`else
    assign w_reject      = w_illegal || w_cross;
    assign w_first_state = BEAT_LAST;
`endif

    // New requests enter when idle or as the final beat retires (back-to-back).
    assign w_req_ready = !rst && ((r_state == IDLE) || ((r_state == BEAT_LAST) && bus.mem_ready));
    assign w_accept    = bus.req_valid && w_req_ready;

    // Keep only the bytes the store size covers, right-aligned.
    always_comb begin
        w_lane_mask = '0;
        w_lane_data = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            w_lane_mask[i]        = (i < 32'(w_bytes));
            w_lane_data[i*8 +: 8] = w_lane_mask[i] ? bus.req_wdata[i*8 +: 8] : 8'h00;
        end
    end

    // Next state: retire the current beat, then let an accepted request override.
    always_comb begin
        w_next    = r_state;
        w_load_lo = 1'b0;
        w_load_hi = 1'b0;
        w_err     = 1'b0;
        case (r_state)
            IDLE: ;
`ifdef STORE_ALIGN_SPLIT_EN
            BEAT_FIRST: begin
                if (bus.mem_ready) begin
                    w_next    = BEAT_LAST;
                    w_load_hi = 1'b1;
                end
            end
`endif
            BEAT_LAST: begin
                if (bus.mem_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (w_accept) begin
            if (w_reject) begin
                w_err  = 1'b1;
                w_next = IDLE;
            end else begin
                w_load_lo = 1'b1;
                w_next    = w_first_state;
            end
        end
    end

    // State and registered beat outputs; beats change only on a load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wmask <= '0;
            r_store_err <= 1'b0;
`ifdef STORE_ALIGN_SPLIT_EN
            r_hi_addr   <= '0;
            r_hi_wdata  <= '0;
            r_hi_wmask  <= '0;
`endif
        end else begin
            r_state     <= w_next;
            r_store_err <= w_err;
            if (w_load_lo) begin
                r_mem_addr  <= w_base;
                r_mem_wdata <= w_lo_data;
                r_mem_wmask <= w_lo_mask;
`ifdef STORE_ALIGN_SPLIT_EN
                r_hi_addr   <= w_base + ADDR_W'(NB);
                r_hi_wdata  <= w_hi_data;
                r_hi_wmask  <= w_hi_mask;
            end else if (w_load_hi) begin
                r_mem_addr  <= r_hi_addr;
                r_mem_wdata <= r_hi_wdata;
                r_mem_wmask <= r_hi_wmask;
`endif
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.mem_valid = (r_state != IDLE);
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wmask = r_mem_wmask;
    assign bus.store_err = r_store_err;
    assign bus.busy      = (r_state != IDLE);
endmodule
